// File: rtl/tmr_fault_injector.sv
// Bounded fault-injection campaign generator for the TMR codec's bit_flip input.
// One flip pattern per RUN cycle (none / walking / pseudo-random / double-copy), all outputs registered.
module tmr_fault_injector #(
  parameter int unsigned WIDTH     = 48,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [15:0]      count,
  output logic [WIDTH-1:0] bit_flip,
  output logic             busy,
  output logic             done,
  output logic [15:0]      inj_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0]  MODE_NONE   = 2'd0;
  localparam logic [1:0]  MODE_WALK   = 2'd1;
  localparam logic [1:0]  MODE_RAND   = 2'd2;
  localparam logic [1:0]  MODE_DOUBLE = 2'd3;
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED_EFF    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  state_t           state_r, state_s;
  logic [1:0]       mode_r, mode_s;
  logic [15:0]      rem_r, rem_s;
  logic [5:0]       ptr_r, ptr_s;
  logic [15:0]      lfsr_r, lfsr_s;
  logic [WIDTH-1:0] flip_r, flip_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [15:0]      inj_r, inj_s;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [5:0] ptr_next(input logic [1:0] m, input logic [5:0] p);
    logic [5:0] r;
    case (m)
      MODE_WALK:   r = (p == 6'd47) ? 6'd0 : p + 6'd1;
      MODE_DOUBLE: r = (p == 6'd15) ? 6'd0 : p + 6'd1;
      default:     r = p;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] flip_pattern(input logic [1:0] m, input logic [5:0] p,
                                                    input logic [15:0] l);
    logic [WIDTH-1:0] one_v;
    logic [WIDTH-1:0] pat;
    logic [5:0]       idx;
    one_v = {{(WIDTH-1){1'b0}}, 1'b1};
    idx   = (l[5:0] >= 6'd48) ? (l[5:0] - 6'd48) : l[5:0];
    case (m)
      MODE_NONE:   pat = {WIDTH{1'b0}};
      MODE_WALK:   pat = one_v << p;
      MODE_RAND:   pat = one_v << idx;
      MODE_DOUBLE: pat = (one_v << p) | (one_v << (p + 6'd16));
      default:     pat = {WIDTH{1'b0}};
    endcase
    return pat;
  endfunction

  // Next-state and next-output logic for the campaign FSM.
  always_comb begin
    state_s = state_r;
    mode_s  = mode_r;
    rem_s   = rem_r;
    ptr_s   = ptr_r;
    lfsr_s  = lfsr_r;
    flip_s  = {WIDTH{1'b0}};
    done_s  = 1'b0;
    inj_s   = inj_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          mode_s = mode;
          rem_s  = count;
          ptr_s  = 6'd0;
          lfsr_s = SEED_EFF;
          inj_s  = 16'd0;
          if (count != 16'd0) begin
            state_s = ST_RUN;
            flip_s  = flip_pattern(mode, 6'd0, SEED_EFF);
          end else begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else begin
          rem_s  = rem_r - 16'd1;
          ptr_s  = ptr_next(mode_r, ptr_r);
          lfsr_s = lfsr_next(lfsr_r);
          // The cycle just ending counts if its pattern was non-zero.
          if ((flip_r != {WIDTH{1'b0}}) && (inj_r != 16'hFFFF)) begin
            inj_s = inj_r + 16'd1;
          end else begin
            inj_s = inj_r;
          end
          if (rem_r == 16'd1) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else begin
            flip_s = flip_pattern(mode_r, ptr_s, lfsr_s);
          end
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
    busy_s = (state_s == ST_RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      mode_r  <= MODE_NONE;
      rem_r   <= 16'd0;
      ptr_r   <= 6'd0;
      lfsr_r  <= SEED_EFF;
      flip_r  <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      inj_r   <= 16'd0;
    end else begin
      state_r <= state_s;
      mode_r  <= mode_s;
      rem_r   <= rem_s;
      ptr_r   <= ptr_s;
      lfsr_r  <= lfsr_s;
      flip_r  <= flip_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      inj_r   <= inj_s;
    end
  end

  assign bit_flip = flip_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign inj_cnt  = inj_r;

endmodule

// File: tb/tb_tmr_fault_injector.sv
// Self-checking bench for tmr_fault_injector: directed campaigns plus randomized ones,
// compared against a cycle-index based reference model of the flip patterns.
module tb_tmr_fault_injector;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [1:0]  mode;
  logic [15:0] count;
  logic [47:0] bit_flip;
  logic        busy;
  logic        done;
  logic [15:0] inj_cnt;

  int checks = 0;
  int errors = 0;
  logic [47:0] obs_q[$];
  logic [47:0] first_q[$];

  tmr_fault_injector #(.WIDTH(48), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .count(count),
    .bit_flip(bit_flip), .busy(busy), .done(done), .inj_cnt(inj_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Polynomial x^16+x^14+x^13+x^11+1: feedback is the parity of bits 15,13,12,10.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], ^(l & 16'hB400)};
  endfunction

  // Expected pattern for RUN cycle i, with l the LFSR value for that cycle.
  function automatic logic [47:0] model_word(input int m, input int i, input logic [15:0] l);
    logic [47:0] one;
    int k;
    one = 48'd1;
    case (m)
      1: return one << (i % 48);
      2: begin
        k = int'(l[5:0]) % 48;
        return one << k;
      end
      3: begin
        k = i % 16;
        return (one << k) | (one << (k + 16));
      end
      default: return 48'd0;
    endcase
  endfunction

  // One campaign; abort_at<0 means run to completion, noise adds ignored start/abort activity.
  task automatic campaign(input int m, input int cnt, input int abort_at, input bit noise);
    logic [47:0] w;
    logic [15:0] l;
    int nz;
    nz = 0;
    l = SEED;
    obs_q.delete();
    start = 1'b1;
    mode  = m[1:0];
    count = cnt[15:0];
    abort = noise;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      w = model_word(m, i, l);
      obs_q.push_back(bit_flip);
      check("flip", {16'd0, bit_flip}, {16'd0, w});
      check("busy_run", {63'd0, busy}, 64'd1);
      check("done_run", {63'd0, done}, 64'd0);
      check("inj_run", {48'd0, inj_cnt}, nz);
      if (m == 2) check("rand_pop", $countones(bit_flip), 64'd1);
      if (noise) start = 1'($urandom_range(0, 1));
      if (i == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_flip", {16'd0, bit_flip}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_inj", {48'd0, inj_cnt}, nz);
        tick();
        check("abort_nodone", {63'd0, done}, 64'd0);
        return;
      end
      if (w != 48'd0) nz++;
      l = lfsr_step(l);
      tick();
    end
    start = 1'b0;
    check("end_flip", {16'd0, bit_flip}, 64'd0);
    check("end_busy", {63'd0, busy}, 64'd0);
    check("end_done", {63'd0, done}, 64'd1);
    check("end_inj", {48'd0, inj_cnt}, nz);
    tick();
    check("post_done", {63'd0, done}, 64'd0);
    check("post_busy", {63'd0, busy}, 64'd0);
    check("post_inj", {48'd0, inj_cnt}, nz);
  endtask

  initial begin
    int m;
    int cnt;
    int ab;
    logic [15:0] l;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 2'd1;
    count = 16'd5;

    // Reset held: start toggling has no effect.
    for (int i = 0; i < 4; i++) begin
      start = 1'(i % 2);
      tick();
      check("rst_flip", {16'd0, bit_flip}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_inj", {48'd0, inj_cnt}, 64'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();

    // Abort alone in IDLE is ignored.
    abort = 1'b1;
    tick();
    tick();
    abort = 1'b0;
    check("idle_abort_busy", {63'd0, busy}, 64'd0);
    check("idle_abort_flip", {16'd0, bit_flip}, 64'd0);

    campaign(1, 50, -1, 1'b0);
    campaign(3, 18, -1, 1'b0);
    campaign(2, 1000, -1, 1'b0);
    first_q = obs_q;
    campaign(2, 1000, -1, 1'b0);
    check("rand_len", obs_q.size(), first_q.size());
    for (int i = 0; i < first_q.size() && i < obs_q.size(); i++) begin
      check("rand_repeat", {16'd0, obs_q[i]}, {16'd0, first_q[i]});
    end
    campaign(0, 0, -1, 1'b0);
    campaign(0, 5, -1, 1'b0);
    campaign(1, 20, 7, 1'b0);
    campaign(3, 9, -1, 1'b1);

    // Reset mid-campaign clears everything immediately.
    l = SEED;
    start = 1'b1;
    mode  = 2'd1;
    count = 16'd20;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("pre_rst_flip", {16'd0, bit_flip}, {16'd0, model_word(1, i, l)});
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_flip", {16'd0, bit_flip}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_done", {63'd0, done}, 64'd0);
    check("mid_rst_inj", {48'd0, inj_cnt}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("after_rst_done", {63'd0, done}, 64'd0);
    check("after_rst_busy", {63'd0, busy}, 64'd0);

    // Randomized campaigns, some aborted, with ignored start/abort noise.
    for (int n = 0; n < 8; n++) begin
      m   = int'($urandom_range(0, 3));
      cnt = int'($urandom_range(0, 70));
      ab  = -1;
      if (cnt > 0 && $urandom_range(0, 2) == 0) ab = int'($urandom_range(0, cnt - 1));
      campaign(m, cnt, ab, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
